// File: rtl/i2c_eeprom_pkg.sv
// Shared types and bit positions for the I2C EEPROM transaction sequencer
// and the controller interface it drives.
package i2c_eeprom_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    CLEAR  = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } seq_state_t;

  localparam logic [2:0] CPU_WREG = 3'd0;
  localparam logic [2:0] CPU_RREG = 3'd1;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_OP_LSB   = 1;
  localparam int CTRL_RATE_LSB = 4;
  localparam int CTRL_CLR      = 7;

  localparam int STAT_FIN    = 1;
  localparam int STAT_ST_LSB = 2;
  localparam int STAT_SMEN   = 10;

  localparam logic [7:0] CTRL_IDLE_ST = 8'd0;

  localparam int CNT_W = 21;

  // Terminal count for a phase lasting cyc cycles, clamped to the counter range.
  function automatic logic [CNT_W-1:0] cnt_last(input int cyc);
    if (cyc <= 1) return '0;
    if (cyc - 1 >= (1 << CNT_W)) return '1;
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/i2c_eeprom_txn_sequencer_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index.
// The pointer moves only when i_adv is high and a request wins.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_adv,
  output logic [N-1:0] o_gnt_onehot
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] win;
  logic          found;

  // First pass looks above the pointer, second pass wraps to the bottom.
  always_comb begin
    o_gnt_onehot = '0;
    win          = last_q;
    found        = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && i_req[k] && (k > int'(last_q))) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && i_req[k]) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
    if (found) o_gnt_onehot[win] = 1'b1;
  end

  // Reset pointer at the top index so index 0 has first priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= PW'(N - 1);
    end else if (i_adv && found) begin
      last_q <= win;
    end
  end

endmodule

// File: rtl/i2c_eeprom_txn_sequencer.sv
// Shares one I2C EEPROM controller between NREQ requesters: one 4-byte
// transfer at a time, finish-clear pulse for reads, write-cycle hold-off.
module i2c_eeprom_txn_sequencer
  import i2c_eeprom_pkg::*;
#(
  parameter int         NREQ        = 2,
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter logic [2:0] CLK_RATE    = 3'd7,
  parameter int         TWR_CYC     = 500000,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         CLR_CYC     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_wr,
  input  logic [NREQ*16-1:0] i_addr,
  input  logic [NREQ*32-1:0] i_wdata,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_done,
  output logic [NREQ-1:0]    o_err,
  output logic [31:0]        o_rdata,
  output logic [31:0]        o_i2c_ctrl,
  output logic [6:0]         o_dev_addr,
  output logic [15:0]        o_reg_addr,
  output logic [31:0]        o_w_data,
  input  logic [31:0]        i_i2c_status,
  input  logic [31:0]        i_rd_byte,
  output logic               o_busy,
  output logic [2:0]         o_dbg_state
);

  localparam logic [CNT_W-1:0] TO_LAST  = cnt_last(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CLR_LAST = cnt_last(CLR_CYC);
  localparam logic [CNT_W-1:0] TWR_LAST = cnt_last(TWR_CYC);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [NREQ-1:0]  gnt_q;
  logic             rd_q;
  logic [15:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             idle_q;

  logic [NREQ-1:0]  arb_gnt;
  logic             adv;
  logic             wr_sel;
  logic [15:0]      addr_sel;
  logic [31:0]      wdata_sel;
  logic             to_hit;
  logic             to_fire;
  logic             rd_fin;
  logic             wr_idle;
  logic             unused_status;

  assign unused_status = ^{i_i2c_status[31:11], i_i2c_status[0]};

  rr_arbiter #(.N(NREQ)) u_arb (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_adv        (adv),
    .o_gnt_onehot (arb_gnt)
  );

  always_comb begin
    wr_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) begin
        wr_sel    = i_wr[k];
        addr_sel  = i_addr[k*16 +: 16];
        wdata_sel = i_wdata[k*32 +: 32];
      end
    end
  end

  // A write never raises finish; it is complete once the controller sits idle.
  assign wr_idle = !i_i2c_status[STAT_SMEN] &&
                   (i_i2c_status[STAT_ST_LSB +: 8] == CTRL_IDLE_ST);
  assign to_hit  = (cnt_q >= TO_LAST);
  assign to_fire = to_hit && ((state_q == LAUNCH) || (state_q == WAIT));
  assign rd_fin  = (state_q == WAIT) && !to_hit && rd_q && i_i2c_status[STAT_FIN];

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          state_d = LAUNCH;
          adv     = 1'b1;
        end
      end
      LAUNCH: begin
        if (to_hit)                         state_d = rd_q ? CLEAR : DONE;
        else if (i_i2c_status[STAT_SMEN])   state_d = WAIT;
      end
      WAIT: begin
        if (to_hit)                         state_d = rd_q ? CLEAR : DONE;
        else if (rd_fin)                    state_d = CLEAR;
        else if (!rd_q && wr_idle && idle_q) state_d = HOLD;
      end
      CLEAR:   if (cnt_q >= CLR_LAST) state_d = DONE;
      HOLD:    if (cnt_q >= TWR_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter restarts on every phase entry except WAIT, so the timeout
  // spans LAUNCH and WAIT together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) && (state_d != WAIT)) cnt_q <= '0;
      else if (cnt_q != '1)                          cnt_q <= cnt_q + 1'b1;
      idle_q <= (state_q == WAIT) && wr_idle;
      if (adv) begin
        gnt_q   <= arb_gnt;
        rd_q    <= !wr_sel;
        addr_q  <= addr_sel;
        wdata_q <= wdata_sel;
        err_q   <= 1'b0;
      end
      if (to_fire) err_q   <= 1'b1;
      if (rd_fin)  rdata_q <= i_rd_byte;
    end
  end

  always_comb begin
    o_i2c_ctrl                      = '0;
    o_i2c_ctrl[CTRL_EN]             = (state_q == LAUNCH);
    o_i2c_ctrl[CTRL_OP_LSB +: 3]    = rd_q ? CPU_RREG : CPU_WREG;
    o_i2c_ctrl[CTRL_RATE_LSB +: 3]  = CLK_RATE;
    o_i2c_ctrl[CTRL_CLR]            = (state_q == CLEAR);
  end

  assign o_gnt       = ((state_q != IDLE) && (state_q != DONE)) ? gnt_q : '0;
  assign o_done      = (state_q == DONE) ? gnt_q : '0;
  assign o_err       = ((state_q == DONE) && err_q) ? gnt_q : '0;
  assign o_rdata     = rdata_q;
  assign o_dev_addr  = DEV_ADDR;
  assign o_reg_addr  = addr_q;
  assign o_w_data    = wdata_q;
  assign o_busy      = (state_q != IDLE);
  assign o_dbg_state = state_q;

endmodule
